// File: rtl/hopfield_current_engine.sv
// Time-multiplexed synaptic-current engine for the Hopfield network.
// Streams the N*N weight matrix out of the Hebbian weight store one word per
// cycle and folds each word into a single accumulator. Finished rows park in
// shadow registers until all N currents are published together with done.
module hopfield_current_engine #(
  parameter int N               = 7,
  parameter int P               = 4,
  parameter int W_WIDTH         = 16,
  parameter int I_WIDTH         = 32,
  parameter int SPIKE_SCALE     = 256,
  parameter int PATTERN_CURRENT = 131072,
  parameter int AW              = $clog2(N * N)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [N-1:0]              spikes,
  input  logic                      learning_enable,
  input  logic [P-1:0]              pattern_input,
  output logic                      w_rd_en,
  output logic [AW-1:0]             w_addr,
  input  logic signed [W_WIDTH-1:0] w_data,
  output logic                      busy,
  output logic                      done,
  output logic [N*I_WIDTH-1:0]      currents_flat
);

  localparam int SHIFT = $clog2(SPIKE_SCALE);
  localparam int IW    = $clog2(N);
  // Row accumulator: worst case N-1 full-scale products, never overflows.
  localparam int ACC_W = W_WIDTH + SHIFT + $clog2(N) + 2;
  // Working width wide enough for accumulator, pattern current and clamp limits.
  localparam int EXT_W = ((ACC_W > I_WIDTH) ? ACC_W : I_WIDTH) + 2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
  localparam logic [IW-1:0] LAST_COL  = IW'(N - 1);

  localparam logic signed [EXT_W-1:0] PAT_EXT = EXT_W'(PATTERN_CURRENT);
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W - I_WIDTH + 1){1'b0}}, {(I_WIDTH - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W - I_WIDTH + 1){1'b1}}, {(I_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    FLUSH   = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  // Clamp a row total into the signed output current range.
  function automatic logic signed [I_WIDTH-1:0] sat_current(input logic signed [EXT_W-1:0] v);
    logic signed [I_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[I_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[I_WIDTH-1:0];
    end else begin
      r = v[I_WIDTH-1:0];
    end
    return r;
  endfunction

  state_t state_r, state_s;

  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              rd_en_r, rd_en_s;
  logic [AW-1:0]     addr_r, addr_s;
  logic [IW-1:0]     i_r, i_s;
  logic [IW-1:0]     j_r, j_s;
  logic              capture_s;
  logic              publish_s;

  logic [N-1:0]      spk_r;
  logic              learn_r;
  logic [N-1:0]      pat_r;

  // Tag of the weight currently arriving on w_data (issued one cycle earlier).
  logic              tag_v_r;
  logic [IW-1:0]     tag_i_r;
  logic [IW-1:0]     tag_j_r;

  logic signed [ACC_W-1:0]   acc_r;
  logic signed [EXT_W-1:0]   term_s;
  logic signed [EXT_W-1:0]   pat_s;
  logic signed [EXT_W-1:0]   sum_s;
  logic signed [I_WIDTH-1:0] sat_s;
  logic                      row_end_s;

  logic signed [I_WIDTH-1:0] shadow_r     [N];
  logic signed [I_WIDTH-1:0] shadow_nxt_s [N];
  logic [N*I_WIDTH-1:0]      currents_r;

  assign busy          = busy_r;
  assign done          = done_r;
  assign w_rd_en       = rd_en_r;
  assign w_addr        = addr_r;
  assign currents_flat = currents_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = RUN; else state_s = IDLE;
      RUN:     if (addr_r == LAST_ADDR) state_s = FLUSH; else state_s = RUN;
      FLUSH:   state_s = PUBLISH;
      PUBLISH: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and read counters.
  always_comb begin
    busy_s    = 1'b0;
    done_s    = 1'b0;
    rd_en_s   = 1'b0;
    addr_s    = addr_r;
    i_s       = i_r;
    j_s       = j_r;
    capture_s = 1'b0;
    publish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          busy_s    = 1'b1;
          rd_en_s   = 1'b1;
          addr_s    = '0;
          i_s       = '0;
          j_s       = '0;
        end else begin
          capture_s = 1'b0;
        end
      end
      RUN: begin
        busy_s = 1'b1;
        if (addr_r == LAST_ADDR) begin
          rd_en_s = 1'b0;
        end else begin
          rd_en_s = 1'b1;
          addr_s  = addr_r + AW'(1);
          if (j_r == LAST_COL) begin
            j_s = '0;
            i_s = i_r + IW'(1);
          end else begin
            j_s = j_r + IW'(1);
          end
        end
      end
      FLUSH: begin
        // Last weight lands this cycle; results go out on the coming edge.
        done_s    = 1'b1;
        publish_s = 1'b1;
      end
      PUBLISH: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Registered outputs, read counters and start-time input snapshots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      addr_r  <= '0;
      i_r     <= '0;
      j_r     <= '0;
      spk_r   <= '0;
      learn_r <= 1'b0;
      pat_r   <= '0;
    end else begin
      busy_r  <= busy_s;
      done_r  <= done_s;
      rd_en_r <= rd_en_s;
      addr_r  <= addr_s;
      i_r     <= i_s;
      j_r     <= j_s;
      if (capture_s) begin
        spk_r   <= spikes;
        learn_r <= learning_enable;
        pat_r   <= N'(pattern_input);
      end
    end
  end

  assign row_end_s = tag_v_r && (tag_j_r == LAST_COL);

  // Contribution of the arriving weight plus the pattern current at row end.
  always_comb begin
    if (tag_v_r && (tag_j_r != tag_i_r) && spk_r[tag_j_r]) begin
      term_s = EXT_W'(w_data) <<< SHIFT;
    end else begin
      term_s = '0;
    end
    if (row_end_s && learn_r && pat_r[tag_i_r]) begin
      pat_s = PAT_EXT;
    end else begin
      pat_s = '0;
    end
    sum_s = EXT_W'(acc_r) + term_s + pat_s;
    sat_s = sat_current(sum_s);
  end

  // Shadow bank as it will be after this edge, with the finishing row folded in.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      if (row_end_s && (tag_i_r == IW'(n))) begin
        shadow_nxt_s[n] = sat_s;
      end else begin
        shadow_nxt_s[n] = shadow_r[n];
      end
    end
  end

  // Accumulator, read-tag pipeline, shadow bank and published currents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_r    <= 1'b0;
      tag_i_r    <= '0;
      tag_j_r    <= '0;
      acc_r      <= '0;
      currents_r <= '0;
      for (int n = 0; n < N; n++) begin
        shadow_r[n] <= '0;
      end
    end else begin
      tag_v_r <= rd_en_r;
      tag_i_r <= i_r;
      tag_j_r <= j_r;
      if (capture_s || row_end_s) begin
        acc_r <= '0;
      end else if (tag_v_r) begin
        acc_r <= ACC_W'(sum_s);
      end
      for (int n = 0; n < N; n++) begin
        shadow_r[n] <= shadow_nxt_s[n];
      end
      if (publish_s) begin
        for (int n = 0; n < N; n++) begin
          currents_r[n*I_WIDTH +: I_WIDTH] <= shadow_nxt_s[n];
        end
      end
    end
  end

endmodule

// File: tb/tb_hopfield_current_engine.sv
// Self-checking bench for hopfield_current_engine: a 32-bit and a 20-bit
// instance run side by side from one weight store; results are compared
// against a plain-arithmetic model of the synaptic-current equation.
module tb_hopfield_current_engine;

  localparam int N  = 7;
  localparam int P  = 4;
  localparam int AW = 6;
  localparam int NN = N * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic                 start;
  logic [N-1:0]         spikes;
  logic                 learning_enable;
  logic [P-1:0]         pattern_input;
  logic                 w_rd_en_a, w_rd_en_b;
  logic [AW-1:0]        w_addr_a, w_addr_b;
  logic signed [15:0]   w_data_a, w_data_b;
  logic                 busy_a, busy_b, done_a, done_b;
  logic [N*32-1:0]      cur_a;
  logic [N*20-1:0]      cur_b;

  logic signed [15:0]   wmem [NN];
  longint               exp_a [N];
  longint               exp_b [N];

  int checks = 0;
  int errors = 0;

  hopfield_current_engine dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .spikes(spikes),
    .learning_enable(learning_enable), .pattern_input(pattern_input),
    .w_rd_en(w_rd_en_a), .w_addr(w_addr_a), .w_data(w_data_a),
    .busy(busy_a), .done(done_a), .currents_flat(cur_a)
  );

  hopfield_current_engine #(.I_WIDTH(20)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .spikes(spikes),
    .learning_enable(learning_enable), .pattern_input(pattern_input),
    .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_data(w_data_b),
    .busy(busy_b), .done(done_b), .currents_flat(cur_b)
  );

  // Weight store with a one-cycle read latency.
  always @(posedge clk) begin
    if (w_rd_en_a) w_data_a <= wmem[w_addr_a];
    if (w_rd_en_b) w_data_b <= wmem[w_addr_b];
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int iw);
    longint mx = (longint'(1) <<< (iw - 1)) - 1;
    longint mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Reference: current[i] = sum_{j!=i} w[i][j]*256*spike[j] (+ pattern), clamped.
  task automatic model(input logic [N-1:0] spk, input logic le, input logic [P-1:0] pat);
    for (int i = 0; i < N; i++) begin
      longint s = 0;
      for (int j = 0; j < N; j++) begin
        if (j != i && spk[j]) s += longint'(wmem[i*N+j]) * 256;
      end
      if (i < P && le && pat[i]) s += 131072;
      exp_a[i] = sat(s, 32);
      exp_b[i] = sat(s, 20);
    end
  endtask

  function automatic longint get_a(input int i);
    return longint'($signed(cur_a[i*32 +: 32]));
  endfunction

  function automatic longint get_b(input int i);
    return longint'($signed(cur_b[i*20 +: 20]));
  endfunction

  task automatic check_currents(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_a%0d", tag, i), get_a(i), exp_a[i]);
      check($sformatf("%s_b%0d", tag, i), get_b(i), exp_b[i]);
    end
  endtask

  // One full computation; with disturb, inputs churn and start re-pulses mid-run.
  task automatic run_op(input string tag, input logic [N-1:0] spk, input logic le,
                        input logic [P-1:0] pat, input bit disturb);
    logic [N*32-1:0] prev_a;
    int done_cyc = 0, done_cnt_a = 0, done_cnt_b = 0;
    int rd_cnt = 0, seq_bad = 0, busy_bad = 0, hold_bad = 0;
    model(spk, le, pat);
    @(negedge clk);
    spikes = spk; learning_enable = le; pattern_input = pat; start = 1'b1;
    prev_a = cur_a;
    for (int cyc = 1; cyc <= 56; cyc++) begin
      @(negedge clk);
      if (done_a) begin
        done_cnt_a++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_b) done_cnt_b++;
      if (w_rd_en_a) begin
        rd_cnt++;
        if (cyc > 49 || w_addr_a != AW'(cyc - 1)) seq_bad++;
      end
      if (busy_a !== (cyc <= 50) || busy_b !== (cyc <= 50)) busy_bad++;
      if (cyc < 51 && cur_a !== prev_a) hold_bad++;
      if (disturb && cyc < 48) begin
        start           = 1'($urandom_range(0, 1));
        spikes          = N'($urandom);
        learning_enable = 1'($urandom);
        pattern_input   = P'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_done_cyc"}, done_cyc, 51);
    check({tag, "_done_cnt_a"}, done_cnt_a, 1);
    check({tag, "_done_cnt_b"}, done_cnt_b, 1);
    check({tag, "_rd_cnt"}, rd_cnt, 49);
    check({tag, "_addr_seq"}, seq_bad, 0);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_hold"}, hold_bad, 0);
    check_currents(tag);
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < NN; k++) wmem[k] = 16'(v);
  endtask

  task automatic fill_random();
    for (int k = 0; k < NN; k++) wmem[k] = 16'($urandom);
  endtask

  initial begin
    int done_seen;
    reset_n = 1'b0; start = 1'b0; spikes = '0;
    learning_enable = 1'b0; pattern_input = '0;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rd_en", w_rd_en_a, 0);
    check("rst_addr", w_addr_a, 0);
    check("rst_cur", longint'(cur_a != '0) + longint'(cur_b != '0), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // All weights 1, all spiking: each neuron sees six neighbours.
    fill(1);
    run_op("ones", 7'h7F, 1'b0, 4'h0, 1'b0);
    check("ones_c0_const", get_a(0), 1536);

    // Distinct weights, huge diagonal, only neuron 3 spiking.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        wmem[i*N+j] = (i == j) ? 16'sd1000 : 16'(10 * i + j);
    run_op("diag", 7'b0001000, 1'b0, 4'h0, 1'b0);
    check("diag_c3_const", get_a(3), 0);
    check("diag_c5_const", get_a(5), 53 * 256);

    // Pattern injection on and off.
    run_op("pat_on", 7'h00, 1'b1, 4'b0101, 1'b0);
    check("pat_c2_const", get_a(2), 131072);
    run_op("pat_off", 7'h00, 1'b0, 4'b0101, 1'b0);

    // Saturation in the 20-bit instance.
    fill(32767);
    run_op("sat_pos", 7'h7F, 1'b0, 4'h0, 1'b0);
    check("sat_pos_const", get_b(4), 524287);
    fill(-32768);
    run_op("sat_neg", 7'h7F, 1'b1, 4'hF, 1'b0);
    check("sat_neg_const", get_b(6), -524288);

    // Input churn and start pulses during a run.
    fill_random();
    run_op("disturb", 7'($urandom), 1'b1, 4'($urandom), 1'b1);

    // Reset asserted at cycle 20 of a run.
    fill_random();
    @(negedge clk);
    spikes = 7'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_rd_en", w_rd_en_a, 0);
    check("mid_rst_cur", longint'(cur_a != '0) + longint'(cur_b != '0), 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    run_op("after_rst", 7'($urandom), 1'b1, 4'($urandom), 1'b0);

    // Random sweeps.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_op($sformatf("rnd%0d", r), 7'($urandom), 1'($urandom), 4'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
